stage_rfread_br_skid: RTL and testbench
=======================================

// Module: stage_rfread_br_skid
// PURPOSE
//  Parametrised register-read stage for the branch/jump unit, between jump-IQ issue and jump EX.
//  Adds valid/ready backpressure via a 2-entry (main+skid) buffer and N-way bypass-select encoding.
//  Decodes jump/branch immediate and op class at capture; drives physical RF read addresses.
//  Optional ROB-age selective flush.
// PARAMETERS
//  PREG_W   6   physical register index width
//  POS_W    6   ROB position width; age compare is modulo 2^POS_W
//  NUM_BYP  2   bypass sources per operand
//  SEL_W    2   src mux select width; must satisfy 2^SEL_W >= NUM_BYP+1
//  IMM_W    20  immediate output width; >= 20
// PORTS
//  clk               in   1        clock, rising edge
//  reset             in   1        synchronous, active-high
//  flush_iq          in   1        full flush: kill all held entries
//  req_issue         in   1        issue valid
//  ready_issue       out  1        stage can accept; registered, = !skid_valid
//  pos/prd_issue     in   POS_W/PREG_W  ROB position / destination preg
//  prs1/prs2_issue   in   PREG_W   source pregs
//  prs1/prs2_valid_issue in 1      source used
//  funct3/funct7_issue in 3/7      raw instr fields
//  rs1/rs2/rd_issue  in   5        raw arch register fields
//  pc_issue          in   32       instruction PC
//  byp1/byp2_issue   in   NUM_BYP  one-hot-or-zero bypass hit per operand
//  req_ex            out  1        main entry valid
//  ready_ex          in   1        EX accepts main entry this cycle
//  pos/prd_ex, funct3_ex, pc_ex out  main entry fields
//  src1/src2_mux     out  SEL_W    0 = regfile, k+1 = bypass source k
//  imm               out  IMM_W    decoded immediate, zero-extended
//  op_mux            out  2        00 jal, 01 jr, 10 jalr, 11 branch
//  prs1/prs2_rfread  out  PREG_W   RF read addresses of main entry
// BEHAVIOUR
//  - Reset: req_ex=0, ready_issue=1, main/skid valid=0, all data outputs 0.
//  - Accept when req_issue & ready_issue. Decode at capture; outputs driven from main regs.
//  - Decode: both prs valid -> op 11, imm={funct7,rd}; neither -> op 00,
//    imm={funct7,rs2,rs1,funct3}; one valid & rd==0 -> op 01, imm=0; else op 10, imm={funct7,rs2}.
//  - Bypass encode: lowest set index k of bypN_issue -> srcN_mux=k+1; none -> 0.
//  - Buffer, per cycle (drain = req_ex & ready_ex):
//    EMPTY (main=0,skid=0): accept -> main; next state MAIN.
//    MAIN: drain & accept -> main replaced; drain only -> EMPTY; accept w/o drain -> skid, state FULL.
//    FULL: ready_issue=0; drain -> skid moves to main, state MAIN; else hold.
//  - Entries leave in issue order; no drop, no duplicate. EX takes at most one entry per cycle.
//  - Stale bypass: entry has a fresh bit, set at capture into main. If the entry is in main and not drained,
//    fresh clears. Fresh also clears when the entry enters skid. srcN_mux is forced to 0 while fresh=0.
//    Bypass data is valid only in the cycle after issue; by then the producer has written the RF.
//  - Priority: reset > flush_iq > selective flush > normal. flush_iq clears main and skid valid.
//    A capture in the same cycle is discarded. ready_issue=1 next cycle.
//  - prs*_rfread follow main entry; hold last value when req_ex=0.
// CONFIGURATION
//  RFREAD_BR_PARTIAL_FLUSH_EN defined: adds ports flush_valid (in,1), flush_pos (in,POS_W), rob_head (in,POS_W).
//    age(p) = (p - rob_head) mod 2^POS_W.
//    While flush_valid=1, any entry (main, skid, or incoming capture) with age(pos) > age(flush_pos) is killed.
//    This applies in the same cycle. If main is killed while skid survives, skid moves to main.
//    No older entry is lost.
//  Not defined: the three ports are absent; only flush_iq kills entries.
// TESTING
//  1 reset held 2 cycles, then released -> req_ex=0, ready_issue=1; after release, req_ex stays 0 with no issue.
//  2 issue prs1/prs2 valid, funct7=7'h15, rd=5'h0A -> next cycle req_ex=1, op_mux=11, imm=20'h002AA.
//  3 issue jr (prs1 only, rd=0), byp1=2'b10, ready_ex=1 -> src1_mux=2, op_mux=01, imm=0, drains in 1 cycle.
//  4 ready_ex=0, issue A then B -> B in skid, ready_issue=0.
//    Set ready_ex=1: A then B out in consecutive cycles, src*_mux=0 for both.
//  5 FULL state with flush_iq=1 and req_issue=1 -> next cycle req_ex=0, ready_issue=1, nothing emitted.
//  6 (PARTIAL_FLUSH_EN) rob_head=60, main pos=62, skid pos=1, flush_pos=63 -> skid killed (wrap age), main kept.
//    Repeat with flush_pos=61 -> both killed.

Source files
------------

// File: rtl/stage_rfread_br_skid_if.sv
// stage_rfread_br_skid_if: issue-side and EX-side bundle for the branch register-read stage (RFREAD_BR_PARTIAL_FLUSH_EN adds flush_valid/flush_pos/rob_head)
interface stage_rfread_br_skid_if #(
  parameter int PREG_W = 6,
  parameter int POS_W = 6,
  parameter int NUM_BYP = 2,
  parameter int SEL_W = 2,
  parameter int IMM_W = 20
);
  logic flush_iq;
  logic req_issue;
  logic ready_issue;
  logic [POS_W-1:0] pos_issue;
  logic [PREG_W-1:0] prd_issue;
  logic [PREG_W-1:0] prs1_issue;
  logic [PREG_W-1:0] prs2_issue;
  logic prs1_valid_issue;
  logic prs2_valid_issue;
  logic [2:0] funct3_issue;
  logic [6:0] funct7_issue;
  logic [4:0] rs1_issue;
  logic [4:0] rs2_issue;
  logic [4:0] rd_issue;
  logic [31:0] pc_issue;
  logic [NUM_BYP-1:0] byp1_issue;
  logic [NUM_BYP-1:0] byp2_issue;
  logic req_ex;
  logic ready_ex;
  logic [POS_W-1:0] pos_ex;
  logic [PREG_W-1:0] prd_ex;
  logic [2:0] funct3_ex;
  logic [31:0] pc_ex;
  logic [SEL_W-1:0] src1_mux;
  logic [SEL_W-1:0] src2_mux;
  logic [IMM_W-1:0] imm;
  logic [1:0] op_mux;
  logic [PREG_W-1:0] prs1_rfread;
  logic [PREG_W-1:0] prs2_rfread;
`ifdef RFREAD_BR_PARTIAL_FLUSH_EN
  logic flush_valid;
  logic [POS_W-1:0] flush_pos;
  logic [POS_W-1:0] rob_head;
`endif
  modport master (
`ifdef RFREAD_BR_PARTIAL_FLUSH_EN
    output flush_valid, flush_pos, rob_head,
`endif
    output flush_iq, req_issue, pos_issue, prd_issue, prs1_issue, prs2_issue,
    output prs1_valid_issue, prs2_valid_issue, funct3_issue, funct7_issue,
    output rs1_issue, rs2_issue, rd_issue, pc_issue, byp1_issue, byp2_issue, ready_ex,
    input ready_issue, req_ex, pos_ex, prd_ex, funct3_ex, pc_ex, src1_mux, src2_mux,
    input imm, op_mux, prs1_rfread, prs2_rfread
  );
  modport slave (
`ifdef RFREAD_BR_PARTIAL_FLUSH_EN
    input flush_valid, flush_pos, rob_head,
`endif
    input flush_iq, req_issue, pos_issue, prd_issue, prs1_issue, prs2_issue,
    input prs1_valid_issue, prs2_valid_issue, funct3_issue, funct7_issue,
    input rs1_issue, rs2_issue, rd_issue, pc_issue, byp1_issue, byp2_issue, ready_ex,
    output ready_issue, req_ex, pos_ex, prd_ex, funct3_ex, pc_ex, src1_mux, src2_mux,
    output imm, op_mux, prs1_rfread, prs2_rfread
  );
endinterface

// File: rtl/stage_rfread_br_skid.sv
// stage_rfread_br_skid: branch/jump register-read stage with main+skid buffer, decode at capture, bypass-select encode; RFREAD_BR_PARTIAL_FLUSH_EN enables ROB-age selective flush
module stage_rfread_br_skid #(
  parameter int PREG_W = 6,
  parameter int POS_W = 6,
  parameter int NUM_BYP = 2,
  parameter int SEL_W = 2,
  parameter int IMM_W = 20
) (
  input logic clk,
  input logic reset,
  stage_rfread_br_skid_if.slave bus
);
  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic [2:0] funct3;
    logic [31:0] pc;
    logic [SEL_W-1:0] s1;
    logic [SEL_W-1:0] s2;
    logic [IMM_W-1:0] imm;
    logic [1:0] op;
  } entry_t;
  entry_t main_q, skid_q, in_d;
  logic main_v, skid_v, fresh;
  logic v1, v2, kill_m, kill_s, kill_in, drain, m_keep, s_keep, acc;
  assign v1 = bus.prs1_valid_issue;
  assign v2 = bus.prs2_valid_issue;
  // decode the incoming instruction and encode the lowest bypass hit per operand
  always_comb begin
    in_d = '0;
    in_d.pos = bus.pos_issue;
    in_d.prd = bus.prd_issue;
    in_d.prs1 = bus.prs1_issue;
    in_d.prs2 = bus.prs2_issue;
    in_d.funct3 = bus.funct3_issue;
    in_d.pc = bus.pc_issue;
    in_d.op = (v1 & v2) ? 2'b11 : !(v1 | v2) ? 2'b00 : (bus.rd_issue == 5'd0) ? 2'b01 : 2'b10;
    in_d.imm = (v1 & v2) ? IMM_W'({bus.funct7_issue, bus.rd_issue}) :
               !(v1 | v2) ? IMM_W'({bus.funct7_issue, bus.rs2_issue, bus.rs1_issue, bus.funct3_issue}) :
               (bus.rd_issue == 5'd0) ? '0 : IMM_W'({bus.funct7_issue, bus.rs2_issue});
    for (int k = NUM_BYP - 1; k >= 0; k--) begin
      if (bus.byp1_issue[k]) in_d.s1 = SEL_W'(k + 1);
      if (bus.byp2_issue[k]) in_d.s2 = SEL_W'(k + 1);
    end
  end
`ifdef RFREAD_BR_PARTIAL_FLUSH_EN
  logic [POS_W-1:0] fage;
  assign fage = POS_W'(bus.flush_pos - bus.rob_head);
  assign kill_m = bus.flush_valid & (POS_W'(main_q.pos - bus.rob_head) > fage);
  assign kill_s = bus.flush_valid & (POS_W'(skid_q.pos - bus.rob_head) > fage);
  assign kill_in = bus.flush_valid & (POS_W'(bus.pos_issue - bus.rob_head) > fage);
`else
  assign kill_m = 1'b0;
  assign kill_s = 1'b0;
  assign kill_in = 1'b0;
`endif
  assign drain = main_v & bus.ready_ex;
  assign m_keep = main_v & !drain & !kill_m;
  assign s_keep = skid_v & !kill_s;
  assign acc = bus.req_issue & !skid_v & !kill_in;
  // buffer advance: surviving entries keep issue order, first goes to main, second to skid
  always_ff @(posedge clk) begin
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      fresh <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (bus.flush_iq) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (m_keep) begin
      fresh <= 1'b0;
      skid_v <= s_keep | acc;
      if (acc) skid_q <= in_d;
    end else if (s_keep) begin
      main_q <= skid_q;
      fresh <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      main_v <= acc;
      skid_v <= 1'b0;
      if (acc) begin
        main_q <= in_d;
        fresh <= 1'b1;
      end
    end
  end
  assign bus.req_ex = main_v;
  assign bus.ready_issue = !skid_v;
  assign bus.pos_ex = main_q.pos;
  assign bus.prd_ex = main_q.prd;
  assign bus.funct3_ex = main_q.funct3;
  assign bus.pc_ex = main_q.pc;
  assign bus.src1_mux = fresh ? main_q.s1 : '0;
  assign bus.src2_mux = fresh ? main_q.s2 : '0;
  assign bus.imm = main_q.imm;
  assign bus.op_mux = main_q.op;
  assign bus.prs1_rfread = main_q.prs1;
  assign bus.prs2_rfread = main_q.prs2;
endmodule

// File: tb/tb_stage_rfread_br_skid.sv
// tb_stage_rfread_br_skid: directed and random checks of the branch register-read stage against a queue model
module tb_stage_rfread_br_skid;
  localparam int PREG_W = 6;
  localparam int POS_W = 6;
  localparam int NUM_BYP = 2;
  localparam int SEL_W = 2;
  localparam int IMM_W = 20;
  typedef struct {
    logic [POS_W-1:0] pos;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] p1;
    logic [PREG_W-1:0] p2;
    logic [2:0] f3;
    logic [31:0] pc;
    logic [SEL_W-1:0] s1;
    logic [SEL_W-1:0] s2;
    logic [IMM_W-1:0] imm;
    logic [1:0] op;
    bit fresh;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  ent_t q[$];
  logic [PREG_W-1:0] last1 = '0;
  logic [PREG_W-1:0] last2 = '0;
  always #5 clk = ~clk;
  stage_rfread_br_skid_if #(.PREG_W(PREG_W), .POS_W(POS_W), .NUM_BYP(NUM_BYP), .SEL_W(SEL_W), .IMM_W(IMM_W)) bus();
  stage_rfread_br_skid #(.PREG_W(PREG_W), .POS_W(POS_W), .NUM_BYP(NUM_BYP), .SEL_W(SEL_W), .IMM_W(IMM_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [NUM_BYP-1:0] rand_byp();
    int idx;
    logic [NUM_BYP-1:0] b;
    idx = $urandom_range(0, NUM_BYP);
    b = '0;
    if (idx < NUM_BYP) b[idx] = 1'b1;
    return b;
  endfunction
  task automatic rand_fields();
    bus.pos_issue = POS_W'($urandom);
    bus.prd_issue = PREG_W'($urandom);
    bus.prs1_issue = PREG_W'($urandom);
    bus.prs2_issue = PREG_W'($urandom);
    bus.prs1_valid_issue = 1'($urandom);
    bus.prs2_valid_issue = 1'($urandom);
    bus.funct3_issue = 3'($urandom);
    bus.funct7_issue = 7'($urandom);
    bus.rs1_issue = 5'($urandom);
    bus.rs2_issue = 5'($urandom);
    bus.rd_issue = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    bus.pc_issue = $urandom;
    bus.byp1_issue = rand_byp();
    bus.byp2_issue = rand_byp();
  endtask
  function automatic ent_t capture();
    ent_t e;
    logic a, b;
    a = bus.prs1_valid_issue;
    b = bus.prs2_valid_issue;
    e.pos = bus.pos_issue;
    e.prd = bus.prd_issue;
    e.p1 = bus.prs1_issue;
    e.p2 = bus.prs2_issue;
    e.f3 = bus.funct3_issue;
    e.pc = bus.pc_issue;
    e.fresh = 1'b0;
    e.s1 = '0;
    e.s2 = '0;
    if (a && b) begin
      e.op = 2'b11;
      e.imm = IMM_W'({bus.funct7_issue, bus.rd_issue});
    end else if (!a && !b) begin
      e.op = 2'b00;
      e.imm = IMM_W'({bus.funct7_issue, bus.rs2_issue, bus.rs1_issue, bus.funct3_issue});
    end else if (bus.rd_issue == 5'd0) begin
      e.op = 2'b01;
      e.imm = '0;
    end else begin
      e.op = 2'b10;
      e.imm = IMM_W'({bus.funct7_issue, bus.rs2_issue});
    end
    for (int k = 0; k < NUM_BYP; k++) if (bus.byp1_issue[k]) begin e.s1 = SEL_W'(k + 1); break; end
    for (int k = 0; k < NUM_BYP; k++) if (bus.byp2_issue[k]) begin e.s2 = SEL_W'(k + 1); break; end
    return e;
  endfunction
`ifdef RFREAD_BR_PARTIAL_FLUSH_EN
  function automatic logic [POS_W-1:0] age(input logic [POS_W-1:0] p);
    return POS_W'(p - bus.rob_head);
  endfunction
`endif
  task automatic model();
    ent_t n[$];
    ent_t e, t;
    bit drain, kin, kl;
    int sz;
    if (reset) begin
      q.delete();
      last1 = '0;
      last2 = '0;
      return;
    end
    if (bus.flush_iq) begin
      q.delete();
      return;
    end
    sz = q.size();
    drain = (sz > 0) && bus.ready_ex;
    e = capture();
    kin = 1'b0;
`ifdef RFREAD_BR_PARTIAL_FLUSH_EN
    if (bus.flush_valid) kin = age(e.pos) > age(bus.flush_pos);
`endif
    for (int i = 0; i < sz; i++) begin
      kl = 1'b0;
`ifdef RFREAD_BR_PARTIAL_FLUSH_EN
      if (bus.flush_valid) kl = age(q[i].pos) > age(bus.flush_pos);
`endif
      if (!kl && !(i == 0 && drain)) begin
        t = q[i];
        t.fresh = 1'b0;
        n.push_back(t);
      end
    end
    if (bus.req_issue && sz < 2 && !kin) begin
      e.fresh = (n.size() == 0);
      n.push_back(e);
    end
    q = n;
    if (q.size() > 0) begin
      last1 = q[0].p1;
      last2 = q[0].p2;
    end
  endtask
  task automatic compare();
    chk("req_ex", bus.req_ex, q.size() > 0);
    chk("ready_issue", bus.ready_issue, q.size() < 2);
    chk("prs1_rfread", bus.prs1_rfread, last1);
    chk("prs2_rfread", bus.prs2_rfread, last2);
    if (q.size() > 0) begin
      chk("pos_ex", bus.pos_ex, q[0].pos);
      chk("prd_ex", bus.prd_ex, q[0].prd);
      chk("funct3_ex", bus.funct3_ex, q[0].f3);
      chk("pc_ex", bus.pc_ex, q[0].pc);
      chk("imm", bus.imm, q[0].imm);
      chk("op_mux", bus.op_mux, q[0].op);
      chk("src1_mux", bus.src1_mux, q[0].fresh ? q[0].s1 : '0);
      chk("src2_mux", bus.src2_mux, q[0].fresh ? q[0].s2 : '0);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    model();
    @(negedge clk);
    compare();
  endtask
  initial begin
    bus.req_issue = 1'b0;
    bus.ready_ex = 1'b0;
    bus.flush_iq = 1'b0;
    rand_fields();
`ifdef RFREAD_BR_PARTIAL_FLUSH_EN
    bus.flush_valid = 1'b0;
    bus.flush_pos = '0;
    bus.rob_head = '0;
`endif
    reset = 1'b1;
    cycle();
    cycle();
    chk("t1_rst_req", bus.req_ex, 1'b0);
    chk("t1_rst_ready", bus.ready_issue, 1'b1);
    chk("t1_rst_imm", bus.imm, 20'h0);
    chk("t1_rst_pc", bus.pc_ex, 32'h0);
    reset = 1'b0;
    cycle();
    cycle();
    chk("t1_idle_req", bus.req_ex, 1'b0);
    rand_fields();
    bus.req_issue = 1'b1;
    bus.prs1_valid_issue = 1'b1;
    bus.prs2_valid_issue = 1'b1;
    bus.funct7_issue = 7'h15;
    bus.rd_issue = 5'h0A;
    bus.ready_ex = 1'b1;
    cycle();
    bus.req_issue = 1'b0;
    chk("t2_req", bus.req_ex, 1'b1);
    chk("t2_op", bus.op_mux, 2'b11);
    chk("t2_imm", bus.imm, 20'h002AA);
    cycle();
    rand_fields();
    bus.req_issue = 1'b1;
    bus.prs1_valid_issue = 1'b1;
    bus.prs2_valid_issue = 1'b0;
    bus.rd_issue = 5'd0;
    bus.byp1_issue = 2'b10;
    cycle();
    bus.req_issue = 1'b0;
    chk("t3_src1", bus.src1_mux, 2'd2);
    chk("t3_op", bus.op_mux, 2'b01);
    chk("t3_imm", bus.imm, 20'h0);
    cycle();
    chk("t3_drained", bus.req_ex, 1'b0);
    bus.ready_ex = 1'b0;
    rand_fields();
    bus.req_issue = 1'b1;
    bus.pos_issue = 6'd5;
    bus.byp1_issue = 2'b01;
    bus.byp2_issue = 2'b10;
    cycle();
    rand_fields();
    bus.pos_issue = 6'd6;
    bus.byp1_issue = 2'b10;
    bus.byp2_issue = 2'b01;
    cycle();
    bus.req_issue = 1'b0;
    chk("t4_full", bus.ready_issue, 1'b0);
    chk("t4_a_pos", bus.pos_ex, 6'd5);
    chk("t4_a_src1", bus.src1_mux, 2'd0);
    chk("t4_a_src2", bus.src2_mux, 2'd0);
    bus.ready_ex = 1'b1;
    cycle();
    chk("t4_b_pos", bus.pos_ex, 6'd6);
    chk("t4_b_src1", bus.src1_mux, 2'd0);
    chk("t4_b_src2", bus.src2_mux, 2'd0);
    cycle();
    chk("t4_empty", bus.req_ex, 1'b0);
    bus.ready_ex = 1'b0;
    rand_fields();
    bus.req_issue = 1'b1;
    cycle();
    rand_fields();
    cycle();
    rand_fields();
    bus.flush_iq = 1'b1;
    cycle();
    bus.flush_iq = 1'b0;
    bus.req_issue = 1'b0;
    chk("t5_req", bus.req_ex, 1'b0);
    chk("t5_ready", bus.ready_issue, 1'b1);
    cycle();
    chk("t5_quiet", bus.req_ex, 1'b0);
`ifdef RFREAD_BR_PARTIAL_FLUSH_EN
    bus.rob_head = 6'd60;
    rand_fields();
    bus.req_issue = 1'b1;
    bus.pos_issue = 6'd62;
    cycle();
    rand_fields();
    bus.pos_issue = 6'd1;
    cycle();
    bus.req_issue = 1'b0;
    bus.flush_valid = 1'b1;
    bus.flush_pos = 6'd63;
    cycle();
    bus.flush_valid = 1'b0;
    chk("t6_main_kept", bus.req_ex, 1'b1);
    chk("t6_main_pos", bus.pos_ex, 6'd62);
    chk("t6_skid_killed", bus.ready_issue, 1'b1);
    rand_fields();
    bus.req_issue = 1'b1;
    bus.pos_issue = 6'd1;
    cycle();
    bus.req_issue = 1'b0;
    bus.flush_valid = 1'b1;
    bus.flush_pos = 6'd61;
    cycle();
    bus.flush_valid = 1'b0;
    chk("t6_both_killed", bus.req_ex, 1'b0);
    chk("t6_both_ready", bus.ready_issue, 1'b1);
`endif
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      bus.req_issue = $urandom_range(0, 9) < 7;
      bus.ready_ex = $urandom_range(0, 9) < 6;
      bus.flush_iq = $urandom_range(0, 29) == 0;
`ifdef RFREAD_BR_PARTIAL_FLUSH_EN
      bus.flush_valid = $urandom_range(0, 19) == 0;
      bus.flush_pos = POS_W'($urandom);
      bus.rob_head = POS_W'($urandom);
`endif
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
